alu_issue_queue: RTL and testbench
==================================

ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of operation-queue entries (power of two, at least 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the upstream operation request is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the queue accepts a request this cycle.
REQ-006 The block SHALL have ports in_a and in_b, input, 4 bits each: operands A and B.
REQ-007 The block SHALL have port in_sel, input, 3 bits: operation select passed unchanged to the ALU.
REQ-008 The block SHALL have port in_use_acc, input, 1 bit: when 1, replace in_a with the accumulator at issue.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_result holds an unconsumed result.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream consumes the result this cycle.
REQ-011 The block SHALL have port out_result, output, 5 bits: the registered ALU output.
REQ-012 The block SHALL have port acc, output, 4 bits: the accumulator, equal to the low 4 bits of the last issued result.
REQ-013 The block SHALL have port count, output, clog2(DEPTH)+1 bits: the queue occupancy.

Function
REQ-014 The block SHALL accept a request on a rising edge where in_valid and in_ready are both 1, writing {in_a, in_b, in_sel, in_use_acc} to the queue tail.
REQ-015 The block SHALL drive in_ready = (count < DEPTH), combinationally from registered count and independent of in_valid; no push occurs when full, even in a cycle that pops.
REQ-016 The block SHALL issue the queue head on an edge where count > 0 and (!out_valid or out_ready); issue pops the head, loads out_result, and sets out_valid.
REQ-017 The block SHALL compute the issued result with the existing combinational ALU (a, b, sel -> 5-bit out), using a = use_acc ? acc : head.a and b = head.b.
REQ-018 The block SHALL update acc to result[3:0] on the same edge as each issue, so back-to-back accumulator operations see the immediately preceding result.
REQ-019 The block SHALL have a latency such that a request accepted on edge k into an empty queue, with the output free, issues on edge k+1; out_valid is high after edge k+1.
REQ-020 The block SHALL sustain a throughput of one issue per cycle while the queue is non-empty and out_ready is 1.
REQ-021 The block SHALL clear out_valid on an edge where out_valid and out_ready are both 1 and no issue occurs.
REQ-022 The block SHALL hold out_result and out_valid stable while out_valid is 1 and out_ready is 0, with no issue and acc unchanged.
REQ-023 The block SHALL, on a simultaneous push and issue, leave count unchanged; the pointers SHALL wrap modulo DEPTH.
REQ-024 The block SHALL not issue when the queue is empty; in_valid arriving with an empty queue is not bypassed.

Reset
REQ-025 The block SHALL, on rst_n low, asynchronously clear count, the pointers, out_valid, out_result and acc to 0, making in_ready 1.
REQ-026 The block SHALL discard queued and in-flight operations on reset asserted mid-operation; no result for them appears after release.
REQ-027 The block SHALL allow the first accept on the first rising edge with rst_n high.

Structure
REQ-028 A shared package alu_pkg SHALL hold OP_W=3, DATA_W=4, RES_W=5 and the queue-entry struct type.
REQ-029 The ALU SHALL be the single sub-module instance (module ALU); the queue storage SHALL be inline, not a separate module.

Verification
REQ-030 Single operation: after reset, push a=5, b=7, sel=0 with out_ready=1 -> out_valid high one edge after accept, and out_result equals the ALU model for (5,7,0).
REQ-031 Fill: hold out_ready=0 and push 5 requests with DEPTH=4 -> the first issues to the output register, count reaches 4, in_ready=0, and the 5th is held until a pop.
REQ-032 Stall: hold out_ready=0 for 3 cycles with out_valid=1 -> out_result stable and acc unchanged; raise out_ready -> next result on the following edge.
REQ-033 Accumulate: push (a=1, b=1, sel=0) then (use_acc=1, b=1, sel=0) back-to-back -> the second result equals the ALU model with a = first result[3:0].
REQ-034 Wrap and simultaneous: run 10 continuous push/pop cycles -> count stays constant, results appear in order, and no loss across pointer wrap.
REQ-035 Reset mid-flight: assert rst_n low with count=3 and out_valid=1 -> all outputs 0, in_ready=1, and no stale result after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared widths and the queue-entry layout for the ALU issue queue.
package alu_pkg;
  localparam int OP_W   = 3;
  localparam int DATA_W = 4;
  localparam int RES_W  = 5;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   sel;
    logic              use_acc;
  } entry_t;
endpackage

// File: rtl/ALU.sv
// Combinational 4-bit ALU with a 5-bit result (carry/borrow in bit 4).
module ALU
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   sel,
  output logic [RES_W-1:0]  result
);
  always_comb begin
    result = '0;
    case (sel)
      3'd0:    result = {1'b0, a} + {1'b0, b};
      3'd1:    result = {1'b0, a} - {1'b0, b};
      3'd2:    result = {1'b0, a & b};
      3'd3:    result = {1'b0, a | b};
      3'd4:    result = {1'b0, a ^ b};
      3'd5:    result = {a, 1'b0};
      3'd6:    result = {2'b00, a[3:1]};
      default: result = {1'b0, b};
    endcase
  end
endmodule

// File: rtl/alu_issue_queue.sv
// Operation queue in front of the ALU with a registered, accumulator-feeding
// result stage. All state is cleared asynchronously by rst_n.
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_a,
  input  logic [DATA_W-1:0]        in_b,
  input  logic [OP_W-1:0]          in_sel,
  input  logic                     in_use_acc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [RES_W-1:0]         out_result,
  output logic [DATA_W-1:0]        acc,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both 1; ready never depends on valid, and valid holds until transferred.
  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            push;
  logic            issue;
  entry_t          head;
  logic [DATA_W-1:0] alu_a;
  logic [RES_W-1:0]  alu_res;

  assign in_ready = (count < CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign issue    = (count != '0) && (!out_valid || out_ready);
  assign head     = mem[rd_ptr];
  assign alu_a    = head.use_acc ? acc : head.a;

  ALU u_alu (
    .a      (alu_a),
    .b      (head.b),
    .sel    (head.sel),
    .result (alu_res)
  );

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{a: in_a, b: in_b, sel: in_sel, use_acc: in_use_acc};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      acc        <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      case ({push, issue})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (issue) begin
        out_result <= alu_res;
        out_valid  <= 1'b1;
        acc        <= alu_res[DATA_W-1:0];
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_issue_queue.sv
// Randomized and directed bench for alu_issue_queue against a queue-based model.
module tb_alu_issue_queue;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct {
    int a;
    int b;
    int sel;
    int ua;
  } op_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_a = '0;
  logic [3:0]    in_b = '0;
  logic [2:0]    in_sel = '0;
  logic          in_use_acc = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [4:0]    out_result;
  logic [3:0]    acc;
  logic [CW-1:0] count;

  int checks = 0;
  int failures = 0;

  op_t        mq[$];
  logic [4:0] exp_q[$];
  bit         m_ov;
  int         m_res;
  int         m_acc;

  alu_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sel(in_sel), .in_use_acc(in_use_acc),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .acc(acc), .count(count)
  );

  always #5 clk = ~clk;

  function automatic int alu_ref(int a, int b, int sel);
    case (sel)
      0: return (a + b) % 32;
      1: return (a - b + 32) % 32;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return (a * 2) % 32;
      6: return a / 2;
      default: return b;
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_ov = 0;
    m_res = 0;
    m_acc = 0;
  endtask

  task automatic check_outputs();
    check("out_valid", out_valid, m_ov);
    check("out_result", out_result, m_res);
    check("acc", acc, m_acc);
    check("count", count, mq.size());
  endtask

  // One clock: predict from the model, let the edge happen, then compare.
  task automatic cycle();
    bit push, iss, consume;
    logic [4:0] shown;
    op_t e;
    int r;
    check("in_ready", in_ready, mq.size() < DEPTH);
    push    = in_valid && (mq.size() < DEPTH);
    iss     = (mq.size() > 0) && (!m_ov || out_ready);
    consume = m_ov && out_ready;
    shown   = out_result;
    @(posedge clk);
    #1;
    if (consume) begin
      if (exp_q.size() == 0) check("consume_underflow", 1, 0);
      else check("consume_order", shown, exp_q.pop_front());
    end
    if (iss) begin
      e = mq.pop_front();
      r = alu_ref(e.ua != 0 ? m_acc : e.a, e.b, e.sel);
      m_res = r;
      m_acc = r % 16;
      m_ov = 1;
      exp_q.push_back(5'(r));
    end else if (consume) begin
      m_ov = 0;
    end
    if (push) mq.push_back('{int'(in_a), int'(in_b), int'(in_sel), int'(in_use_acc)});
    check_outputs();
  endtask

  task automatic drive(bit v, int a, int b, int sel, bit ua);
    in_valid = v;
    in_a = 4'(a);
    in_b = 4'(b);
    in_sel = 3'(sel);
    in_use_acc = ua;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check("reset_in_ready", in_ready, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #2;
    do_reset();

    // Single operation: 5 + 7.
    out_ready = 1'b1;
    drive(1, 5, 7, 0, 0);
    cycle();
    check("single_latency", out_valid, 0);
    drive(0, 0, 0, 0, 0);
    cycle();
    check("single_valid", out_valid, 1);
    check("single_result", out_result, 12);
    cycle();

    // Fill with the output stalled; the fifth request must wait.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7), 0);
      cycle();
    end
    check("fill_count", count, DEPTH);
    check("fill_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) cycle();
    out_ready = 1'b1;
    cycle();
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cycle();

    // Accumulate back-to-back: 1+1, then acc+1.
    drive(1, 1, 1, 0, 0);
    cycle();
    drive(1, 9, 1, 0, 1);
    cycle();
    drive(0, 0, 0, 0, 0);
    cycle();
    check("accum_result", out_result, 3);
    check("accum_acc", acc, 3);
    cycle();

    // Continuous push/pop across pointer wrap.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, i + 2, 3, 0, 0);
      cycle();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7),
            1'($urandom_range(0, 1)));
      cycle();
      check("wrap_count", count, 2);
    end
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle();

    // Reset with work queued and a result pending.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1, i, i + 1, 0, 0);
      cycle();
    end
    drive(0, 0, 0, 0, 0);
    check("midflight_count", count, 3);
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 7), 1'($urandom_range(0, 1)));
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
